// File: rtl/iob_reg_file_mp.sv
// ----------------------------------------------------------------------------
// iob_reg_file_mp
//   Multi-read-port register file. It has one column-masked write port and
//   N_RD independent registered read ports. A clear sweep zeroes the whole
//   array one word per cycle. Reset is asynchronous and active-low. It zeroes
//   the array, the read registers and the sweep control without a clock edge,
//   which is why the array is built from flops rather than block RAM.
//
// Parameters
//   NUM_COL    : write-enable columns per word
//   COL_WIDTH  : bits per column
//   DATA_WIDTH : word width, must equal NUM_COL*COL_WIDTH
//   ADDR_WIDTH : address width, DEPTH = 2**ADDR_WIDTH words
//   N_RD       : number of read ports (1..8)
//   BYPASS     : 1 = write-first forwarding on a read/write collision,
//                0 = the read returns the old contents
//
// Ports
//   clk    : clock, all logic on the rising edge
//   rst    : asynchronous reset, active-low
//   w_en   : per-column write enable
//   w_addr : write address
//   w_data : write data, column c = bits [c*COL_WIDTH +: COL_WIDTH]
//   r_addr : packed read addresses, port p = slice p
//   r_data : packed registered read data, port p = slice p
//   clr    : request a clear sweep (ignored while a sweep is running)
//   busy   : sweep in progress, writes are dropped while high
// ----------------------------------------------------------------------------
module iob_reg_file_mp #(
    parameter int NUM_COL    = 2,
    parameter int COL_WIDTH  = 4,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int ADDR_WIDTH = 4,
    parameter int N_RD       = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_COL-1:0]           w_en,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic [N_RD*ADDR_WIDTH-1:0]   r_addr,
    output logic [N_RD*DATA_WIDTH-1:0]   r_data,
    input  logic                         clr,
    output logic                         busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_busy;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    assign busy = r_busy;

    // ------------------------------------------------------------------
    // Clear-sweep FSM. busy is a registered copy of "state == SWEEP". It is
    // high for ptr = 0 .. DEPTH-1, which is exactly DEPTH cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr) begin
                        r_state <= ST_SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    // clr is deliberately not looked at here: no restart, no extension
                    r_ptr <= r_ptr + 1'b1;
                    if (&r_ptr) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage array. While sweeping, the only write is the zero at ptr.
    // User writes are dropped for the whole sweep.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_busy) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int c = 0; c < NUM_COL; c++) begin
                if (w_en[c]) begin
                    r_mem[w_addr][c*COL_WIDTH +: COL_WIDTH] <= w_data[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Each port has its own output register with 1-cycle latency.
    // Forwarding only applies when a user write can actually land, which
    // means never while busy.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_RD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd_next;
        logic [DATA_WIDTH-1:0] r_rd;

        assign w_ra = r_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_rd_next = r_mem[w_ra];
            if ((BYPASS != 0) && !r_busy && (w_ra == w_addr)) begin
                for (int c = 0; c < NUM_COL; c++) begin
                    if (w_en[c]) begin
                        w_rd_next[c*COL_WIDTH +: COL_WIDTH] = w_data[c*COL_WIDTH +: COL_WIDTH];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd <= '0;
            end else begin
                r_rd <= w_rd_next;
            end
        end

        assign r_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_rd;
    end

endmodule

// File: tb/tb_iob_reg_file_mp.sv
// ----------------------------------------------------------------------------
// tb_iob_reg_file_mp
//   Scoreboard bench for iob_reg_file_mp. It instantiates two copies that
//   share all inputs, one built with BYPASS=1 and one with BYPASS=0. A
//   reference model of the word array and the sweep counter produces the
//   expected read data and busy level for every clock. These expectations
//   go into a queue, and a negedge monitor pops them and compares.
// ----------------------------------------------------------------------------
module tb_iob_reg_file_mp;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  w_en = '0;
    logic [3:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
    logic [7:0]  r_addr = '0;
    logic        clr = 1'b0;
    logic [15:0] r_data1, r_data0;
    logic        busy1, busy0;

    always #5 clk = ~clk;

    iob_reg_file_mp #(.BYPASS(1)) u_dut_bp1 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_addr(r_addr), .r_data(r_data1), .clr(clr), .busy(busy1)
    );

    iob_reg_file_mp #(.BYPASS(0)) u_dut_bp0 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r_addr(r_addr), .r_data(r_data0), .clr(clr), .busy(busy0)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         due;   // cycle count at which the value must be visible
        int         kind;  // 0 = read data, 1 = busy
        int         dut;   // 1 = BYPASS=1 copy, 0 = BYPASS=0 copy
        int         port;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // ---------------- reference model ----------------
    logic [7:0] mm [DEPTH];
    bit         m_busy = 1'b0;
    int         m_ptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] wd,
                                         input logic [1:0] we);
        logic [7:0] res;
        res = old;
        for (int c = 0; c < 2; c++) begin
            if (we[c]) res[c*4 +: 4] = wd[c*4 +: 4];
        end
        return res;
    endfunction

    function automatic logic [7:0] actual(input int dut, input int kind, input int port);
        logic [15:0] rd;
        rd = (dut == 1) ? r_data1 : r_data0;
        if (kind == 1) return {7'd0, (dut == 1) ? busy1 : busy0};
        return rd[port*8 +: 8];
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
                chk("stale_expectation", 16'(e.due), 16'(cyc));
            end else begin
                chk($sformatf("%s_dut_bp%0d_p%0d", (e.kind == 1) ? "busy" : "rdata",
                              e.dut, e.port),
                    {8'd0, actual(e.dut, e.kind, e.port)}, {8'd0, e.exp});
            end
        end
    end

    // Apply one cycle of stimulus. The task is entered just after a rising
    // edge and returns just after the next one.
    task automatic step(input logic [1:0] we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic [3:0] ra0, input logic [3:0] ra1, input bit c);
        logic [3:0] a;
        logic [7:0] old;
        logic [7:0] fwd;
        w_en = we; w_addr = wa; w_data = wd; r_addr = {ra1, ra0}; clr = c;
        $display("[TB] cyc=%0d we=%b wa=%0d wd=%h ra0=%0d ra1=%0d clr=%0b busy_model=%0b",
                 cyc, we, wa, wd, ra0, ra1, c, m_busy);
        for (int p = 0; p < 2; p++) begin
            a   = (p == 0) ? ra0 : ra1;
            old = mm[a];
            fwd = (!m_busy && a == wa) ? merge(old, wd, we) : old;
            q.push_back('{cyc + 1, 0, 1, p, fwd});
            q.push_back('{cyc + 1, 0, 0, p, old});
        end
        if (m_busy) begin
            mm[m_ptr] = 8'h00;
            m_ptr++;
            if (m_ptr == DEPTH) m_busy = 1'b0;
        end else begin
            mm[wa] = merge(mm[wa], wd, we);
            if (c) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end
        end
        q.push_back('{cyc + 1, 1, 1, 0, {7'd0, m_busy}});
        q.push_back('{cyc + 1, 1, 0, 0, {7'd0, m_busy}});
        @(posedge clk); #1;
    endtask

    // Assert reset between clock edges and check that it takes effect at once.
    // Then hold it while write and clr stay active, and release it just after
    // an edge.
    task automatic do_reset(input int hold);
        #1 rst = 1'b0;
        #1;
        $display("[TB] cyc=%0d async reset asserted", cyc);
        chk("rst_busy_bp1", {15'd0, busy1}, 16'd0);
        chk("rst_busy_bp0", {15'd0, busy0}, 16'd0);
        chk("rst_rdata_bp1", r_data1, 16'd0);
        chk("rst_rdata_bp0", r_data0, 16'd0);
        q.delete();
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
        m_busy = 1'b0;
        m_ptr  = 0;
        w_en = 2'b11; w_data = 8'hFF; w_addr = 4'($urandom); clr = 1'b1;
        r_addr = 8'($urandom);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("rst_hold_rdata_bp1", r_data1, 16'd0);
            chk("rst_hold_busy_bp1", {15'd0, busy1}, 16'd0);
        end
        rst = 1'b1; w_en = 2'b00; clr = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(2'b00, 4'd0, 8'h00, 4'(a), 4'(DEPTH - 1 - a), 1'b0);
    endtask

    task automatic fill_index();
        for (int i = 0; i < DEPTH; i++) step(2'b11, 4'(i), 8'(i), 4'(i), 4'(i), 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
        @(posedge clk); #1;
        do_reset(2);

        // Reset contents on both ports
        read_all();

        // Column-masked write
        step(2'b01, 4'd3, 8'hAB, 4'd3, 4'd3, 1'b0);
        step(2'b00, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0);
        step(2'b10, 4'd3, 8'hCD, 4'd3, 4'd3, 1'b0);
        step(2'b00, 4'd0, 8'h00, 4'd3, 4'd3, 1'b0);

        // Dual-port reads
        fill_index();
        step(2'b00, 4'd0, 8'h00, 4'd2, 4'd9, 1'b0);
        step(2'b00, 4'd0, 8'h00, 4'd7, 4'd7, 1'b0);

        // Read/write collision
        step(2'b11, 4'd5, 8'h11, 4'd0, 4'd0, 1'b0);
        step(2'b11, 4'd5, 8'h5A, 4'd5, 4'd5, 1'b0);
        step(2'b00, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0);

        // Full sweep with a dropped write at sweep cycle 8
        fill_index();
        step(2'b00, 4'd0, 8'h00, 4'd0, 4'd1, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            step((k == 8) ? 2'b11 : 2'b00, 4'd0, 8'hFF, 4'($urandom), 4'($urandom),
                 (k == 4) ? 1'b1 : 1'b0);
        end
        read_all();

        // Reset during a sweep
        fill_index();
        step(2'b00, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);
        for (int k = 0; k < 7; k++) step(2'b00, 4'd0, 8'h00, 4'(k), 4'(k + 8), 1'b0);
        do_reset(1);
        read_all();
        step(2'b11, 4'd1, 8'h33, 4'd0, 4'd0, 1'b0);
        step(2'b00, 4'd0, 8'h00, 4'd1, 4'd1, 1'b0);

        // Random traffic with occasional sweeps and resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1 + $urandom_range(0, 2));
            end else begin
                step(2'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
                     ($urandom_range(0, 29) == 0));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_reg_file_mp.md
IOB_REG_FILE_MP -- requirements
Module: iob_reg_file_mp

Interface
REQ-001 SHALL have parameter NUM_COL, default 2, number of write-enable columns per word.
REQ-002 SHALL have parameter COL_WIDTH, default 4, bits per column.
REQ-003 SHALL have parameter DATA_WIDTH, default NUM_COL*COL_WIDTH, word width; other values are illegal.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4, giving DEPTH = 2**ADDR_WIDTH words.
REQ-005 SHALL have parameter N_RD, default 2, number of independent read ports (1..8).
REQ-006 SHALL have parameter BYPASS, default 1; 1 = write-first forwarding, 0 = read-old.
REQ-007 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset; one clock, asynchronous, active-low (asserted at 0).
REQ-009 SHALL have port w_en  input  NUM_COL  per-column write enable.
REQ-010 SHALL have port w_addr  input  ADDR_WIDTH  write address.
REQ-011 SHALL have port w_data  input  DATA_WIDTH  write data; column c = bits [c*COL_WIDTH +: COL_WIDTH].
REQ-012 SHALL have port r_addr  input  N_RD*ADDR_WIDTH  packed read addresses; port p = slice p.
REQ-013 SHALL have port r_data  output  N_RD*DATA_WIDTH  packed registered read data; port p = slice p.
REQ-014 SHALL have port clr  input  1  request synchronous clear sweep.
REQ-015 SHALL have port busy  output  1  clear sweep in progress; writes are dropped while high.

Function
REQ-016 Write: SHALL update column c of word w_addr at the rising edge when w_en[c]=1 and busy=0; other columns unchanged.
REQ-017 Write with w_en=0 SHALL leave the memory unchanged.
REQ-018 Read: each port SHALL register mem[r_addr_p] into r_data_p every cycle; latency exactly 1 cycle, no read enable.
REQ-019 Ports reading the same address in the same cycle SHALL all return identical data.
REQ-020 BYPASS=1: when port p reads the address being written in the same cycle, enabled columns of r_data_p SHALL take w_data and disabled columns the stored value.
REQ-021 BYPASS=0: a same-cycle read/write collision SHALL return the pre-write contents.
REQ-022 Clear FSM SHALL have two states, IDLE and SWEEP; reset state IDLE.
REQ-023 IDLE -> SWEEP SHALL occur at the edge where clr=1; the sweep pointer loads 0 and busy=1 from the next cycle.
REQ-024 In SWEEP, each cycle SHALL write all-zero to word[ptr] and increment ptr by 1.
REQ-025 At ptr = DEPTH-1 SHALL zero that word and return to IDLE; busy is high for exactly DEPTH cycles.
REQ-026 clr while in SWEEP SHALL be ignored (no restart, no extension).
REQ-027 During SWEEP reads SHALL continue and return current contents (zeroed or not yet swept); BYPASS forwarding SHALL be inactive because writes are dropped.
REQ-028 A write dropped during busy SHALL have no effect before, during or after the sweep.

Reset
REQ-029 rst=0 SHALL immediately, without a clock edge, zero every memory word, every r_data_p, busy and ptr, and force IDLE.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep; after release the block is idle, busy=0 and all words zero.
REQ-031 Writes and clr SHALL be ignored while rst=0; the first write is accepted at the first rising edge after release.

Verification
REQ-032 Reset: rst pulse low, then read addr 0..15 on both ports -> r_data = 0 each cycle after.
REQ-033 Column write: addr 3, w_en=01, w_data=0xAB -> read 0x0B; then w_en=10, w_data=0xCD -> read 0xCB.
REQ-034 Dual port: fill word i with i; port0 reads 2 and port1 reads 9 in the same cycle -> 0x02 and 0x09 one cycle later; both ports read 7 -> 0x07 on both.
REQ-035 Collision: word 5 = 0x11; write 0x5A to 5 with w_en=11 while port0 reads 5 -> BYPASS=1 gives 0x5A, BYPASS=0 gives 0x11 then 0x5A.
REQ-036 Sweep: fill word i with i, pulse clr -> busy high exactly 16 cycles; write 0xFF to addr 0 at sweep cycle 8 is dropped; afterwards all 16 words read 0.
REQ-037 Reset mid-sweep: clr, then rst=0 at sweep cycle 7 -> busy falls at once, no clock needed; after release all words read 0 and a write to addr 1 with 0x33 reads back 0x33.
